// File: rtl/mem_arbiter.sv
// Two-master round-robin front end for the SRAM controller: one-entry request
// buffer toward the tagged mem_* port and tag-based demux of returned burst data.
module mem_arbiter #(
    parameter int unsigned burst_bits   = 2,
    parameter int unsigned burst_length = 1 << burst_bits
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic [29:0] m0_address,
    input  logic        m0_read,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,
    input  logic [29:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_writedatamask,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,
    input  logic        mem_waitrequest,
    output logic [1:0]  mem_id,
    output logic [29:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_writedatamask,
    input  logic [31:0] mem_readdata,
    input  logic [1:0]  mem_readdataid
);

    localparam int unsigned CW = burst_bits + 1;
    localparam logic [CW-1:0] BURST_LOAD = CW'(burst_length);

    logic          valid_q, valid_d;
    logic [1:0]    id_q, id_d;
    logic [29:0]   addr_q, addr_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    mask_q, mask_d;
    logic          ptr_q, ptr_d;
    logic [CW-1:0] outst0_q, outst0_d;
    logic [CW-1:0] outst1_q, outst1_d;
    logic [31:0]   r0_data_q, r0_data_d;
    logic          r0_valid_q, r0_valid_d;
    logic [31:0]   r1_data_q, r1_data_d;
    logic          r1_valid_q, r1_valid_d;

    logic consumed, free, elig0, elig1, gnt0, gnt1;

    always_comb begin
        consumed = valid_q & ~mem_waitrequest;
        free     = ~valid_q | consumed;
        // rst_n gating keeps both waitrequests high for the whole reset window
        elig0    = rst_n & free & m0_read & (outst0_q == '0);
        elig1    = rst_n & free & (m1_read ? (outst1_q == '0) : m1_write);
        gnt0     = elig0 & (~elig1 | ptr_q);
        gnt1     = elig1 & (~elig0 | ~ptr_q);
    end

    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        if (gnt0) begin
            valid_d = 1'b1;
            id_d    = 2'd1;
            addr_d  = m0_address;
            rd_d    = 1'b1;
            wr_d    = 1'b0;
            data_d  = '0;
            mask_d  = '0;
            ptr_d   = 1'b0;
        end else if (gnt1) begin
            valid_d = 1'b1;
            id_d    = 2'd2;
            addr_d  = m1_address;
            rd_d    = m1_read;
            wr_d    = ~m1_read;
            data_d  = m1_writedata;
            mask_d  = m1_writedatamask;
            ptr_d   = 1'b1;
        end else if (consumed) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        outst0_d = outst0_q;
        outst1_d = outst1_q;
        if (gnt0) begin
            outst0_d = BURST_LOAD;
        end else if (mem_readdataid == 2'd1 && outst0_q != '0) begin
            outst0_d = outst0_q - 1'b1;
        end
        if (gnt1 && m1_read) begin
            outst1_d = BURST_LOAD;
        end else if (mem_readdataid == 2'd2 && outst1_q != '0) begin
            outst1_d = outst1_q - 1'b1;
        end
    end

    always_comb begin
        r0_data_d  = r0_data_q;
        r1_data_d  = r1_data_q;
        r0_valid_d = (mem_readdataid == 2'd1);
        r1_valid_d = (mem_readdataid == 2'd2);
        if (r0_valid_d) r0_data_d = mem_readdata;
        if (r1_valid_d) r1_data_d = mem_readdata;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            id_q       <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            data_q     <= '0;
            mask_q     <= '0;
            ptr_q      <= 1'b0;
            outst0_q   <= '0;
            outst1_q   <= '0;
            r0_data_q  <= '0;
            r0_valid_q <= 1'b0;
            r1_data_q  <= '0;
            r1_valid_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            ptr_q      <= ptr_d;
            outst0_q   <= outst0_d;
            outst1_q   <= outst1_d;
            r0_data_q  <= r0_data_d;
            r0_valid_q <= r0_valid_d;
            r1_data_q  <= r1_data_d;
            r1_valid_q <= r1_valid_d;
        end
    end

    assign m0_waitrequest    = ~gnt0;
    assign m1_waitrequest    = ~gnt1;
    assign mem_read          = valid_q & rd_q;
    assign mem_write         = valid_q & wr_q;
    assign mem_id            = id_q;
    assign mem_address       = addr_q;
    assign mem_writedata     = data_q;
    assign mem_writedatamask = mask_q;
    assign m0_readdata       = r0_data_q;
    assign m0_readdatavalid  = r0_valid_q;
    assign m1_readdata       = r1_data_q;
    assign m1_readdatavalid  = r1_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: return-path vector table, directed multi-cycle
// sequences, and randomized traffic against a transaction-level model.
module tb_mem_arbiter;

    localparam int BL = 4;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [29:0] m0_address;
    logic        m0_read;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic        m0_readdatavalid;
    logic [29:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writedata;
    logic [3:0]  m1_writedatamask;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;
    logic        m1_readdatavalid;
    logic        mem_waitrequest;
    logic [1:0]  mem_id;
    logic [29:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_writedatamask;
    logic [31:0] mem_readdata;
    logic [1:0]  mem_readdataid;

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.burst_bits(2)) dut (
        .clock(clock), .rst_n(rst_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_writedatamask(m1_writedatamask),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_waitrequest(mem_waitrequest), .mem_id(mem_id), .mem_address(mem_address),
        .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_writedatamask(mem_writedatamask), .mem_readdata(mem_readdata),
        .mem_readdataid(mem_readdataid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
    } ret_vec_t;

    ret_vec_t tbl[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        m0_read = 0; m1_read = 0; m1_write = 0; mem_waitrequest = 0;
        mem_readdataid = 0; m0_address = 0; m1_address = 0;
        m1_writedata = 0; m1_writedatamask = 0; mem_readdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clock);
        #1 rst_n = 1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_memctl"}, {mem_read, mem_write, mem_id}, 4'b0);
        chk({tag, "_memdat"}, {mem_address, mem_writedata, mem_writedatamask}, '0);
        chk({tag, "_ret"}, {m0_readdatavalid, m0_readdata, m1_readdatavalid, m1_readdata}, '0);
        chk({tag, "_wait"}, {m0_waitrequest, m1_waitrequest}, 2'b11);
    endtask

    // Transaction-level reference state for the random phase
    logic        mv, mrd, mwr, r0v, r1v;
    int          mptr, out0, out1;
    logic [1:0]  mid;
    logic [29:0] maddr;
    logic [31:0] mdata, r0d, r1d;
    logic [3:0]  mmask;

    initial begin
        tbl[0] = '{2'd1, 32'h1111_1111, 1'b1, 32'h1111_1111, 1'b0, 32'h0};
        tbl[1] = '{2'd2, 32'h2222_2222, 1'b0, 32'h1111_1111, 1'b1, 32'h2222_2222};
        tbl[2] = '{2'd0, 32'h3333_3333, 1'b0, 32'h1111_1111, 1'b0, 32'h2222_2222};
        tbl[3] = '{2'd3, 32'h4444_4444, 1'b0, 32'h1111_1111, 1'b0, 32'h2222_2222};
        tbl[4] = '{2'd2, 32'h5555_5555, 1'b0, 32'h1111_1111, 1'b1, 32'h5555_5555};
        tbl[5] = '{2'd1, 32'h6666_6666, 1'b1, 32'h6666_6666, 1'b0, 32'h5555_5555};

        // Reset state, with requests and a return tag present during reset
        idle_inputs();
        rst_n = 1;
        #1 rst_n = 0;
        m0_read = 1; m1_read = 1; m1_write = 1; mem_readdataid = 2'd1;
        mem_readdata = 32'hFFFF_FFFF;
        tick();
        chk_reset_outputs("reset");
        do_reset();

        // Return-path demux table
        foreach (tbl[i]) begin
            mem_readdataid = tbl[i].id;
            mem_readdata   = tbl[i].data;
            tick();
            chk($sformatf("tbl%0d_m0", i), {m0_readdatavalid, m0_readdata}, {tbl[i].v0, tbl[i].d0});
            chk($sformatf("tbl%0d_m1", i), {m1_readdatavalid, m1_readdata}, {tbl[i].v1, tbl[i].d1});
        end

        // Single master 0 read, burst return, re-accept once drained
        do_reset();
        m0_address = 30'h100; m0_read = 1;
        #1;
        chk("m0_accept_wait", {m0_waitrequest, m1_waitrequest}, 2'b01);
        tick();
        m0_read = 0;
        chk("m0_issue", {mem_read, mem_write, mem_id, mem_address}, {1'b1, 1'b0, 2'd1, 30'h100});
        tick();
        chk("m0_consumed", {mem_read, mem_write}, 2'b00);
        m0_read = 1;
        for (int i = 0; i < BL; i++) begin
            mem_readdataid = 2'd1;
            mem_readdata   = 32'hA0 + 32'(i);
            #1;
            chk($sformatf("m0_blocked%0d", i), m0_waitrequest, 1'b1);
            tick();
            chk($sformatf("m0_beat%0d", i), {m0_readdatavalid, m0_readdata, m1_readdatavalid},
                {1'b1, 32'hA0 + 32'(i), 1'b0});
        end
        mem_readdataid = 2'd0;
        #1;
        chk("m0_reaccept", m0_waitrequest, 1'b0);
        tick();
        m0_read = 0;
        chk("m0_after_burst", {m0_readdatavalid, m0_readdata}, {1'b0, 32'hA3});

        // Simultaneous reads: pointer at master 0 favours master 1
        do_reset();
        m0_address = 30'h10; m1_address = 30'h20; m0_read = 1; m1_read = 1;
        #1;
        chk("both_first_wait", {m0_waitrequest, m1_waitrequest}, 2'b10);
        tick();
        m1_read = 0;
        chk("both_first_issue", {mem_read, mem_id, mem_address}, {1'b1, 2'd2, 30'h20});
        #1;
        chk("both_second_wait", {m0_waitrequest, m1_waitrequest}, 2'b01);
        tick();
        m0_read = 0;
        chk("both_second_issue", {mem_read, mem_id, mem_address}, {1'b1, 2'd1, 30'h10});

        // Write held under downstream backpressure
        do_reset();
        mem_waitrequest = 1;
        m1_write = 1; m1_address = 30'h55; m1_writedata = 32'hDEAD_BEEF; m1_writedatamask = 4'h3;
        #1;
        chk("wr_accept_wait", m1_waitrequest, 1'b0);
        tick();
        m1_writedata = 32'h1234_5678; m1_writedatamask = 4'hC;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("wr_hold%0d", i),
                {mem_write, mem_read, mem_id, mem_address, mem_writedata, mem_writedatamask},
                {1'b1, 1'b0, 2'd2, 30'h55, 32'hDEAD_BEEF, 4'h3});
            chk($sformatf("wr_hold_wait%0d", i), m1_waitrequest, 1'b1);
            tick();
        end
        mem_waitrequest = 0;
        #1;
        chk("wr_consume_cycle", {mem_write, mem_writedata, m1_waitrequest}, {1'b1, 32'hDEAD_BEEF, 1'b0});
        tick();
        m1_write = 0;
        chk("wr_next_loaded", {mem_write, mem_writedata, mem_writedatamask}, {1'b1, 32'h1234_5678, 4'hC});
        tick();
        chk("wr_drained", mem_write, 1'b0);

        // Asynchronous reset in the middle of a master 1 burst
        do_reset();
        m1_address = 30'h77; m1_read = 1;
        tick();
        m1_read = 0;
        mem_readdataid = 2'd2; mem_readdata = 32'hCAFE_0001;
        tick();
        chk("mid_beat", {m1_readdatavalid, m1_readdata}, {1'b1, 32'hCAFE_0001});
        m1_read = 1; m1_address = 30'h99;
        #2 rst_n = 0;
        #1;
        chk_reset_outputs("async");
        mem_readdataid = 2'd0;
        @(negedge clock);
        rst_n = 1;
        #1;
        chk("post_reset_wait", m1_waitrequest, 1'b0);
        tick();
        m1_read = 0;
        chk("post_reset_issue", {mem_read, mem_id, mem_address}, {1'b1, 2'd2, 30'h99});

        // Randomized traffic against the reference model
        do_reset();
        mv = 0; mrd = 0; mwr = 0; mid = 0; maddr = 0; mdata = 0; mmask = 0;
        mptr = 0; out0 = 0; out1 = 0; r0v = 0; r1v = 0; r0d = 0; r1d = 0;
        for (int c = 0; c < 3000; c++) begin
            bit free, e0, e1;
            int winner, r;
            m0_read          = ($urandom % 3) == 0;
            m0_address       = 30'($urandom);
            m1_read          = ($urandom % 4) == 0;
            m1_write         = ($urandom % 4) == 0;
            m1_address       = 30'($urandom);
            m1_writedata     = $urandom;
            m1_writedatamask = 4'($urandom);
            mem_waitrequest  = ($urandom % 3) == 0;
            mem_readdata     = $urandom;
            r = int'($urandom % 8);
            mem_readdataid = 2'd0;
            if (r < 3 && out0 > 0) mem_readdataid = 2'd1;
            else if (r >= 3 && r < 6 && out1 > 0) mem_readdataid = 2'd2;
            else if (r == 7) mem_readdataid = 2'd3;
            #1;

            free = !mv || !mem_waitrequest;
            e0 = m0_read && free && out0 == 0;
            e1 = free && (m1_read ? out1 == 0 : m1_write);
            if (e0 && e1) winner = 1 - mptr;
            else if (e0) winner = 0;
            else if (e1) winner = 1;
            else winner = -1;

            chk("rnd_wait", {m0_waitrequest, m1_waitrequest}, {winner != 0, winner != 1});
            chk("rnd_mem", {mem_read, mem_write, mem_id, mem_address, mem_writedata, mem_writedatamask},
                {mv && mrd, mv && mwr, mid, maddr, mdata, mmask});
            chk("rnd_ret", {m0_readdatavalid, m0_readdata, m1_readdatavalid, m1_readdata},
                {r0v, r0d, r1v, r1d});

            if (mem_readdataid == 2'd1 && out0 > 0) out0--;
            if (mem_readdataid == 2'd2 && out1 > 0) out1--;
            if (winner == 0) begin
                mv = 1; mid = 2'd1; maddr = m0_address; mrd = 1; mwr = 0;
                mdata = 0; mmask = 0; out0 = BL; mptr = 0;
            end else if (winner == 1) begin
                mv = 1; mid = 2'd2; maddr = m1_address; mrd = m1_read; mwr = !m1_read;
                mdata = m1_writedata; mmask = m1_writedatamask; mptr = 1;
                if (m1_read) out1 = BL;
            end else if (mv && !mem_waitrequest) begin
                mv = 0;
            end
            r0v = (mem_readdataid == 2'd1);
            r1v = (mem_readdataid == 2'd2);
            if (r0v) r0d = mem_readdata;
            if (r1v) r1d = mem_readdata;
            @(posedge clock);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master front end for the SRAM controller: merges master 0 (instruction fetch) and master 1 (data) onto the single tagged mem_* request port.
- Registers each granted request in a one-entry request buffer.
- Demultiplexes tagged burst read data back to the owning master.
- Sits directly upstream of the SRAM controller. Its downstream side matches that controller's mem_* port exactly.

Parameters:
- burst_bits, 2, log2 of read burst length; must equal the controller's burst_bits.
- burst_length, 1 << burst_bits, read words returned per accepted read.

Ports:
- clock  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- m0_address  in  30  master 0 word address.
- m0_read  in  1  master 0 burst read request.
- m0_waitrequest  out  1  high = master 0 request not accepted this cycle.
- m0_readdata  out  32  master 0 read data.
- m0_readdatavalid  out  1  one-cycle pulse per returned word.
- m1_address  in  30  master 1 word address.
- m1_read  in  1  master 1 burst read request.
- m1_write  in  1  master 1 single-word write request.
- m1_writedata  in  32  master 1 write data.
- m1_writedatamask  in  4  master 1 byte enables, 1 = write byte.
- m1_waitrequest  out  1  high = master 1 request not accepted.
- m1_readdata  out  32  master 1 read data.
- m1_readdatavalid  out  1  one-cycle pulse per returned word.
- mem_waitrequest  in  1  downstream busy.
- mem_id  out  2  request tag: 1 = master 0, 2 = master 1 (0 is reserved for "no data").
- mem_address  out  30  downstream address.
- mem_read  out  1  downstream read.
- mem_write  out  1  downstream write.
- mem_writedata  out  32  downstream write data.
- mem_writedatamask  out  4  downstream byte enables.
- mem_readdata  in  32  returned word.
- mem_readdataid  in  2  tag of returned word, 0 = none.

Behaviour:
- Reset (rst_n low, async):
  - Request buffer empty, so mem_read = mem_write = 0.
  - mem_id, mem_address, mem_writedata, mem_writedatamask = 0.
  - Readdata outputs 0; readdatavalid outputs 0.
  - Round-robin pointer = master 0; both outstanding counters = 0.
  - m0_waitrequest = m1_waitrequest = 1 while rst_n is low.
- Request buffer: one entry {valid, id, address, rd, wr, data, mask}.
  - mem_read = valid & rd; mem_write = valid & wr. Other mem_* outputs come straight from the buffer.
  - Buffer is consumed on a clock edge where valid & !mem_waitrequest.
  - free = !valid | consumed (combinational).
- Eligibility:
  - Master k is eligible when it asserts a request, free = 1, and outst_k = 0 (reads only; a write from master 1 ignores outst_1).
  - m1_read and m1_write asserted together count as a read; the write waits.
- Arbitration (combinational):
  - One eligible master is granted.
  - Both eligible: the master not equal to the pointer wins; on grant the pointer <= granted master.
  - Granted master sees waitrequest = 0 in the same cycle. All non-granted or ineligible masters see waitrequest = 1.
  - A master with no request sees waitrequest = 1.
- Buffer load:
  - On a grant edge the buffer loads the master's fields, id = k+1, valid = 1.
  - Earliest mem_read is one cycle after the master's accept cycle.
  - No grant and consumed: valid <= 0.
- Outstanding counters (burst_bits+1 bits each):
  - A read accepted from master k loads outst_k <= burst_length.
  - Each mem_readdataid == k+1 decrements outst_k.
  - Load and decrement never coincide, because load requires outst_k = 0.
  - Decrement at 0 is ignored (saturate) and must never occur in legal traffic.
- Return path, 1-cycle latency:
  - mem_readdataid == 1: m0_readdata <= mem_readdata, m0_readdatavalid <= 1.
  - mem_readdataid == 2: same for master 1.
  - mem_readdataid == 0 or 3: no valid pulse; readdata holds its last value.
- Writes produce no return. A write may be accepted while the same master's read burst is outstanding; ordering is then the downstream's order.
- Reset mid-burst: counters clear and the buffer empties. Any data still returned after reset is discarded only if its tag is 0. No recovery protocol beyond that.

Test Plan:
- Reset, then m0_read with m0_address=0x100 and idle downstream → m0_waitrequest=0 in the request cycle; next cycle mem_read=1, mem_address=0x100, mem_id=1.
- Downstream returns ids 1,1,1,1 with data A0..A3 on cycles T..T+3 → m0_readdatavalid high T+1..T+4 with A0..A3; outst_0 reaches 0; the next m0_read is then accepted.
- m0_read and m1_read held together, pointer=0 → master 1 granted first, master 0 after free; mem_id sequence 2 then 1.
- m1_write with writedata 0xDEADBEEF and mask 0x3 while mem_waitrequest=1 for 3 cycles → buffer holds, m1_waitrequest stays 1 for new requests, mem_write held 3 cycles, consumed on the 4th.
- m0_read issued while outst_0=2 → m0_waitrequest stays 1 until 2 more id=1 beats arrive; accepted the cycle outst_0=0.
- rst_n pulsed low mid-burst → all outputs at reset values immediately (async); after release, a fresh m1_read issues normally with mem_id=2.
